sel_decoder_seq: RTL and testbench
==================================

Name: sel_decoder_seq

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder; successor to the combinational 5-to-32 select decoder.
- Drives register-file write-enable lines and select lines in test/BIST fixtures.
- Adds three behaviours the combinational decoder lacks: registered output with enable, optional index-0 suppression (hard-wired zero register), and a built-in sweep sequencer that walks every select value in order.

Parameters:
- SEL_W, 5: select width. Output width OUT_W = 2^SEL_W (derived localparam). Legal range 1..6.
- ZERO_MASK, 1: when 1, decoding index 0 produces all-zero m in every mode.
- SWEEP_HOLD, 1: cycles each sweep index is held on m. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  output enable; 0 forces m to zero and pauses the sweep
- mode  in  2  00 direct, 01 sweep, 10 hold, 11 treated as hold
- sel  in  SEL_W  select value used in direct mode
- start  in  1  single-cycle request to begin a sweep (mode 01 only)
- m  out  OUT_W  registered one-hot decode
- cur_sel  out  SEL_W  index currently driven on m
- busy  out  1  high while sweep in progress
- done  out  1  single-cycle pulse at sweep completion

Behaviour:
- Reset (async, rst_n=0):
  - m=0, cur_sel=0, busy=0, done=0.
  - FSM goes to IDLE; hold counter=0.
  - Takes effect immediately, including mid-sweep. First update after release is on the first rising edge with rst_n=1.
- Decode rule:
  - m = 1 << cur_sel_next, computed to OUT_W bits.
  - If ZERO_MASK=1 and the index is 0, m=0.
  - m is always one-hot or zero, never multi-hot.
- Direct mode (mode=00, FSM IDLE), latency 1 cycle:
  - en=1: at edge, cur_sel<=sel and m<=decode(sel).
  - en=0: m<=0; cur_sel holds.
- Hold mode (10/11): m and cur_sel hold their last values; en=0 still forces m<=0 at the next edge.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE->SWEEP: mode=01 and start=1 and en=1 at an edge. That edge sets cur_sel<=0, m<=decode(0), hold counter<=0, busy<=1.
  - SWEEP, en=1: hold counter increments each cycle. When it reaches SWEEP_HOLD-1, it clears and cur_sel advances by 1 with m updated on the same edge.
  - SWEEP, last index: when cur_sel=OUT_W-1 and the hold count expires, go to DONE. m<=0, busy<=0, done<=1, cur_sel holds OUT_W-1.
  - DONE->IDLE: unconditionally after one cycle; done<=0.
  - SWEEP, en=0: counter and cur_sel freeze, m<=0. On en returning to 1, m<=decode(cur_sel) and counting resumes. The hold count does not restart.
  - SWEEP, mode != 01 at an edge: abort to IDLE. busy<=0, m<=0, no done pulse.
  - start while busy=1: ignored. start in any mode other than 01: ignored.
- Total sweep length with en held high: OUT_W*SWEEP_HOLD cycles from the start edge to the done edge. busy is high for exactly those cycles.
- cur_sel counter never wraps during a sweep. It wraps only by a new start, which resets it to 0.

Test Plan:
- Reset then direct: release rst_n, mode=00, en=1, sel=5'd7 -> one cycle later m=32'h0000_0080, cur_sel=7. sel=0 -> m=0 with ZERO_MASK=1; m=32'h1 with ZERO_MASK=0.
- Enable gating: direct mode, sel=31, en toggled 1/0/1 -> m=32'h8000_0000 / 0 / 32'h8000_0000, each 1 cycle after the en change.
- Full sweep: SWEEP_HOLD=1, mode=01, start pulse.
  - busy high for 32 cycles.
  - m steps 0 (masked), 2, 4 ... 32'h8000_0000.
  - done pulses once on the 33rd edge; m=0 afterwards.
  - Checker asserts m is one-hot or zero every cycle.
- Pause and abort:
  - en=0 for 3 cycles at cur_sel=10 -> m=0 and cur_sel stays 10; on resume sweep continues at 10 and ends 3 cycles late.
  - mode->00 at cur_sel=20 -> busy=0 next edge, no done pulse.
- Async reset mid-sweep: assert rst_n at cur_sel=15 between clock edges -> m, busy, cur_sel go to 0 immediately, without waiting for a clock edge. A second start after release restarts at index 0.
- Parameter sweep: SEL_W=3, SWEEP_HOLD=4 -> 32 busy cycles, each index held 4 cycles, m width 8.

Source files
------------

// File: rtl/sel_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot select decoder with output enable,
// optional index-0 suppression and a built-in sweep sequencer that walks
// every select value in ascending order, holding each for SWEEP_HOLD cycles.
module sel_decoder_seq #(
  parameter int unsigned SEL_W      = 5,
  parameter int unsigned ZERO_MASK  = 1,
  parameter int unsigned SWEEP_HOLD = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    start,
  output logic [(1<<SEL_W)-1:0]   m,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned         OUT_W     = 1 << SEL_W;
  localparam logic [SEL_W-1:0]    LAST_SEL  = SEL_W'(OUT_W - 1);
  localparam logic [7:0]          HOLD_LAST = 8'(SWEEP_HOLD - 1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SWEEP  = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [SEL_W-1:0] sel_inc;

  // One-hot decode; index 0 yields all-zero when the zero register is masked.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    decode = '0;
    if (!((ZERO_MASK != 0) && (idx == '0)))
      decode[idx] = 1'b1;
  endfunction

  // Next sweep index (never wraps in use: the last index terminates the sweep).
  always_comb begin
    sel_inc = cur_sel + SEL_W'(1);
  end

  // Sequencer FSM with registered decode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m        <= '0;
      cur_sel  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mode == MODE_SWEEP && start && en) begin
            state    <= SWEEP;
            cur_sel  <= '0;
            m        <= decode('0);
            hold_cnt <= '0;
            busy     <= 1'b1;
          end else if (!en) begin
            m <= '0;
          end else if (mode == MODE_DIRECT) begin
            cur_sel <= sel;
            m       <= decode(sel);
          end
          // mode 01 without a start, and modes 10/11, hold m and cur_sel.
        end

        SWEEP: begin
          if (mode != MODE_SWEEP) begin
            state <= IDLE;
            busy  <= 1'b0;
            m     <= '0;
          end else if (!en) begin
            // Paused: index and hold count freeze, output blanked.
            m <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (cur_sel == LAST_SEL) begin
              state <= DONE;
              m     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cur_sel <= sel_inc;
              m       <= decode(sel_inc);
            end
          end else begin
            // Re-decode the current index so a resume after a pause restores m.
            hold_cnt <= hold_cnt + 8'd1;
            m        <= decode(cur_sel);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_decoder_seq.sv
// Self-checking bench for sel_decoder_seq: default 5-bit instance, a
// ZERO_MASK=0 twin sharing its inputs, and a 3-bit / hold-4 instance.
module tb_sel_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, start;
  logic [1:0]  mode;
  logic [4:0]  sel;
  logic [31:0] m0, m1;
  logic [4:0]  cs0, cs1;
  logic        busy0, busy1, done0, done1;

  logic        en2, start2;
  logic [1:0]  mode2;
  logic [2:0]  sel2;
  logic [7:0]  m2;
  logic [2:0]  cs2;
  logic        busy2, done2;

  typedef struct packed {
    logic [31:0] m;
    logic [4:0]  cs;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t sb[$];
  obs_t got, want;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sel_decoder_seq #(.SEL_W(5), .ZERO_MASK(1), .SWEEP_HOLD(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .m(m0), .cur_sel(cs0), .busy(busy0), .done(done0)
  );

  sel_decoder_seq #(.SEL_W(5), .ZERO_MASK(0), .SWEEP_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .m(m1), .cur_sel(cs1), .busy(busy1), .done(done1)
  );

  sel_decoder_seq #(.SEL_W(3), .ZERO_MASK(1), .SWEEP_HOLD(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel(sel2), .start(start2),
    .m(m2), .cur_sel(cs2), .busy(busy2), .done(done2)
  );

  // m must never be multi-hot on either masked instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if ($countones(m0) > 1 || $countones(m2) > 1) begin
        bad++;
        $display("FAIL onehot: m0=%h m2=%h required one-hot or zero", m0, m2);
      end
    end
  end

  function automatic obs_t mk(input logic [31:0] mm, input int c, input logic b, input logic d);
    mk.m    = mm;
    mk.cs   = 5'(c);
    mk.busy = b;
    mk.done = d;
  endfunction

  // Expected masked decode of an index.
  function automatic logic [31:0] dec(input int i);
    dec = (i == 0) ? 32'h0 : (32'h1 << i);
  endfunction

  function automatic obs_t obs0();
    obs0 = '{m: m0, cs: cs0, busy: busy0, done: done0};
  endfunction

  function automatic obs_t obs2();
    obs2 = '{m: {24'h0, m2}, cs: {2'b00, cs2}, busy: busy2, done: done2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; start = 1'b0; mode = 2'b00; sel = '0;
    en2 = 1'b0; start2 = 1'b0; mode2 = 2'b00; sel2 = '0;
    #1;
    sb.push_back(mk(32'h0, 0, 1'b0, 1'b0));
    sb.push_back(mk(32'h0, 0, 1'b0, 1'b0));
    step();
    step();
    got = obs0(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset0: got %h required %h", got, want);
    end
    got = obs2(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset2: got %h required %h", got, want);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    int sels[3] = '{7, 0, 5};
    mode = 2'b00; en = 1'b1;
    foreach (sels[i]) begin
      sel = 5'(sels[i]);
      sb.push_back(mk(dec(sels[i]), sels[i], 1'b0, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL direct sel=%0d: got %h required %h", sels[i], got, want);
      end
      total++;
      if (m1 !== (32'h1 << sels[i])) begin
        bad++;
        $display("FAIL direct_nomask sel=%0d: got m=%h required %h", sels[i], m1, 32'h1 << sels[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic ens[3] = '{1'b1, 1'b0, 1'b1};
    mode = 2'b00; sel = 5'd31;
    foreach (ens[i]) begin
      en = ens[i];
      sb.push_back(mk(ens[i] ? 32'h8000_0000 : 32'h0, 31, 1'b0, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL en_gate step=%0d: got %h required %h", i, got, want);
      end
    end
  endtask

  task automatic test_hold_mode();
    logic [1:0] modes[3] = '{2'b10, 2'b10, 2'b11};
    logic       ens[3]   = '{1'b1, 1'b0, 1'b1};
    logic [31:0] ms[3]   = '{32'h8000_0000, 32'h0, 32'h0};
    foreach (modes[i]) begin
      mode = modes[i]; en = ens[i]; sel = 5'(3 + i);
      sb.push_back(mk(ms[i], 31, 1'b0, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL hold step=%0d: got %h required %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sels[5] = '{3, 17, 0, 30, 1};
    mode = 2'b00; en = 1'b1; start = 1'b1;  // start outside mode 01 is ignored
    foreach (sels[i]) begin
      sel = 5'(sels[i]);
      sb.push_back(mk(dec(sels[i]), sels[i], 1'b0, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL b2b sel=%0d: got %h required %h", sels[i], got, want);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_full_sweep();
    mode = 2'b01; en = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      start = (k == 0) || (k == 5);  // second pulse lands while busy
      if (k <= 31)      sb.push_back(mk(dec(k), k, 1'b1, 1'b0));
      else if (k == 32) sb.push_back(mk(32'h0, 31, 1'b0, 1'b1));
      else              sb.push_back(mk(32'h0, 31, 1'b0, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL sweep k=%0d: got %h required %h", k, got, want);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_pause();
    int c;
    mode = 2'b01;
    for (int j = 0; j <= 36; j++) begin
      start = (j == 0);
      en    = !(j >= 11 && j <= 13);
      if (j <= 10)      c = j;
      else if (j <= 13) c = 10;
      else if (j <= 34) c = j - 3;
      else              c = 31;
      if (j >= 11 && j <= 13) sb.push_back(mk(32'h0, c, 1'b1, 1'b0));
      else if (j <= 34)       sb.push_back(mk(dec(c), c, 1'b1, 1'b0));
      else if (j == 35)       sb.push_back(mk(32'h0, c, 1'b0, 1'b1));
      else                    sb.push_back(mk(32'h0, c, 1'b0, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pause j=%0d: got %h required %h", j, got, want);
      end
    end
    start = 1'b0; en = 1'b1;
  endtask

  task automatic test_abort();
    en = 1'b1;
    for (int j = 0; j <= 23; j++) begin
      start = (j == 0);
      mode  = (j >= 21) ? 2'b00 : 2'b01;
      sel   = 5'd9;
      if (j <= 20)      sb.push_back(mk(dec(j), j, 1'b1, 1'b0));
      else if (j == 21) sb.push_back(mk(32'h0, 20, 1'b0, 1'b0));
      else              sb.push_back(mk(32'h0000_0200, 9, 1'b0, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL abort j=%0d: got %h required %h", j, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b01; en = 1'b1;
    for (int j = 0; j <= 15; j++) begin
      start = (j == 0);
      sb.push_back(mk(dec(j), j, 1'b1, 1'b0));
      step();
      got = obs0(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL areset_pre j=%0d: got %h required %h", j, got, want);
      end
    end
    start = 1'b0;
    #3;
    rst_n = 1'b0;
    sb.push_back(mk(32'h0, 0, 1'b0, 1'b0));
    #1;
    got = obs0(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL areset_immediate: got %h required %h", got, want);
    end
    step();
    rst_n = 1'b1;
    start = 1'b1;
    sb.push_back(mk(32'h0, 0, 1'b1, 1'b0));
    step();
    got = obs0(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL areset_restart0: got %h required %h", got, want);
    end
    start = 1'b0;
    sb.push_back(mk(32'h2, 1, 1'b1, 1'b0));
    step();
    got = obs0(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL areset_restart1: got %h required %h", got, want);
    end
    mode = 2'b00;
    sb.push_back(mk(32'h0, 1, 1'b0, 1'b0));
    step();
    got = obs0(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++;
      $display("FAIL areset_abort: got %h required %h", got, want);
    end
  endtask

  task automatic test_param_sweep();
    int idx;
    mode2 = 2'b01; en2 = 1'b1;
    for (int j = 0; j <= 33; j++) begin
      start2 = (j == 0);
      idx = j / 4;
      if (j <= 31)      sb.push_back(mk(dec(idx), idx, 1'b1, 1'b0));
      else if (j == 32) sb.push_back(mk(32'h0, 7, 1'b0, 1'b1));
      else              sb.push_back(mk(32'h0, 7, 1'b0, 1'b0));
      step();
      got = obs2(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL param_sweep j=%0d: got %h required %h", j, got, want);
      end
    end
    start2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_enable_gating();
    test_hold_mode();
    test_back_to_back();
    test_full_sweep();
    test_pause();
    test_abort();
    test_async_reset();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
